// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_t       : controller FSM encoding
//   BASE_ADDR_DEF : byte address that maps to SRAM word 0
//   SRAM_DW       : external SRAM data width
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int          SRAM_DW       = 16;

endpackage

// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM
// as two halfword phases (high half first, big-endian), each with
// WAIT_CYCLES strobe cycles plus one recovery/sample cycle.
// Ports:
//   clk, rst            : clock, async active-low reset
//   mem_r_en, mem_w_en  : requests held by the pipeline until ready
//   address, data       : byte address and write data
//   data_memory_out     : last completed read word
//   ready               : high when idle or in the single completion cycle
//   sram_*              : external SRAM address, data and active-low strobes
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            data,
  output logic [31:0]            data_memory_out,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [SRAM_DW-1:0]     sram_dq_in,
  output logic [SRAM_DW-1:0]     sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int IW = SRAM_ADDR_W - 1;  // word index width

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                wr_q;     // latched operation: 1 = write
  logic                inr_q;    // latched address-in-range flag
  logic [IW-1:0]       idx_q;    // latched SRAM word index
  logic [31:0]         wdata_q;
  logic [SRAM_DW-1:0]  rhi_q;    // high halfword captured in HI phase
  logic [31:0]         dmo_q;

  logic [31:0] offs;
  logic        in_range;
  logic        req;
  logic        last;

  assign offs = address - 32'(BASE_ADDR);
  // index < 2^IW  <=>  byte offset < 2^(IW+2) = 2^(SRAM_ADDR_W+1)
  assign in_range = (address >= 32'(BASE_ADDR)) &&
                    ((offs >> (SRAM_ADDR_W + 1)) == 32'd0);
  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt_q == CW'(WAIT_CYCLES));

  assign data_memory_out = dmo_q;

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = HI;
      end
      HI, LO: begin
        if (last) state_d = (state_q == HI) ? LO : DONE;
        // out-of-range accesses run the handshake with the chip deselected
        if (inr_q) begin
          sram_ce_n = 1'b0;
          sram_addr = {idx_q, (state_q == LO)};
          if (wr_q) begin
            sram_dq_oe  = 1'b1;
            sram_dq_out = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
            sram_we_n   = last;  // last cycle releases WE for write recovery
          end else begin
            sram_oe_n = 1'b0;
          end
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      inr_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rhi_q   <= '0;
      dmo_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req) begin
            wr_q    <= mem_w_en;  // write wins over a simultaneous read
            inr_q   <= in_range;
            idx_q   <= offs[IW+1:2];
            wdata_q <= data;
          end
        end
        HI: begin
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last && !wr_q) rhi_q <= inr_q ? sram_dq_in : '0;
        end
        LO: begin
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          // publish the full word so it is visible in the DONE cycle
          if (last && !wr_q) dmo_q <= {rhi_q, (inr_q ? sram_dq_in : 16'h0)};
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller with a behavioural SRAM
// and a word-level reference memory.
module tb_sram_controller;

  localparam int W        = 1;
  localparam int AW       = 18;
  localparam int BASE     = 1024;
  localparam int EXP_LAT  = 2 * (W + 1) + 1;
  localparam int IDX_LIM  = 1 << (AW - 1);

  logic          clk, rst;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   address, data, data_memory_out;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_in, sram_dq_out;
  logic          sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;

  sram_controller #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .data(data),
    .data_memory_out(data_memory_out), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // behavioural SRAM: halfword array, writes land while CE and WE are low
  logic [15:0] smem [0:2*IDX_LIM-1];
  int ce_cnt = 0;
  int we_cnt = 0;
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? smem[sram_addr] : 16'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (!sram_ce_n) ce_cnt++;
      if (!sram_ce_n && !sram_we_n) begin
        we_cnt++;
        smem[sram_addr] = sram_dq_out;
      end
    end
  end

  // reference model: word-addressed memory
  typedef struct { logic rd; logic [31:0] data; } exp_t;
  exp_t        sbq[$];
  logic [31:0] ref_mem [int];

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'(BASE)) && (((a - 32'(BASE)) >> 2) < 32'(IDX_LIM));
  endfunction

  task automatic push_op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   k;
    k = int'((a - 32'(BASE)) >> 2);
    if (w) begin
      e.rd = 1'b0; e.data = '0;
      if (in_rng(a)) ref_mem[k] = d;
    end else begin
      e.rd   = r;
      e.data = (in_rng(a) && ref_mem.exists(k)) ? ref_mem[k] : 32'h0;
    end
    sbq.push_back(e);
  endtask

  task automatic start_op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    push_op(r, w, a, d);
    mem_r_en = r; mem_w_en = w; address = a; data = d;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready) begin seen = 1; break; end
    end
    if (!seen) begin
      bad++; total++;
      $display("FAIL wait_ready: got timeout want ready");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    start_op(r, w, a, d);
    wait_done();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ce_n"}, sram_ce_n, 1);
    chk({tag, "_we_n"}, sram_we_n, 1);
    chk({tag, "_oe_n"}, sram_oe_n, 1);
    chk({tag, "_dq_oe"}, sram_dq_oe, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_dq_out"}, sram_dq_out, 0);
    chk({tag, "_ready"}, ready, 0);
  endtask

  // monitor: latency, completion-cycle strobes, read data, idle behaviour
  initial begin
    int   lat;
    exp_t e;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!rst) lat = 0;
      else if (mem_r_en || mem_w_en) begin
        if (!ready) lat++;
        else begin
          chk("latency", lat, EXP_LAT);
          chk("done_ce_n", sram_ce_n, 1);
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done want none");
          end else begin
            e = sbq.pop_front();
            if (e.rd) chk("read_data", data_memory_out, e.data);
          end
          lat = 0;
        end
      end else begin
        chk("idle_ready", ready, 1);
        chk("idle_ce_n", sram_ce_n, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int sel;
    logic [31:0] a;
    for (int i = 0; i < 2*IDX_LIM; i++) smem[i] = 16'h0;
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; data = '0;
    #2;
    // reset held with a write pending
    start_op(0, 1, 32'd1028, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    chk("rst_dmo", data_memory_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("hi_ce_n", sram_ce_n, 0);
    chk("hi_addr", sram_addr, 2);
    chk("hi_dq", sram_dq_out, 16'hDEAD);
    chk("hi_we_n", sram_we_n, 0);
    chk("hi_dq_oe", sram_dq_oe, 1);
    @(posedge clk); #1;
    chk("hi_rec_we_n", sram_we_n, 1);
    chk("hi_rec_addr", sram_addr, 2);
    @(posedge clk); #1;
    chk("lo_addr", sram_addr, 3);
    chk("lo_dq", sram_dq_out, 16'hBEEF);
    chk("lo_we_n", sram_we_n, 0);
    wait_done();
    idle_in();
    chk("sram_word2", smem[2], 16'hDEAD);
    chk("sram_word3", smem[3], 16'hBEEF);
    chk("we_pulses", we_cnt, 2);

    issue(1, 0, 32'd1028, 32'h0); idle_in();
    repeat (4) @(posedge clk); #1;

    // simultaneous request: write wins
    issue(1, 1, 32'd1032, 32'h12345678); idle_in();
    issue(1, 0, 32'd1032, 32'h0); idle_in();
    chk("rw_readback", data_memory_out, 32'h12345678);

    // out of range read
    c0 = ce_cnt;
    issue(1, 0, 32'd512, 32'h0); idle_in();
    chk("oor_ce", ce_cnt - c0, 0);
    chk("oor_dmo", data_memory_out, 0);

    // inputs changing mid-access are ignored
    start_op(0, 1, 32'd1036, 32'hA5A55A5A);
    @(posedge clk); #1;
    address = 32'd1100; data = 32'h0;
    chk("mid_addr_hi", sram_addr, 6);
    chk("mid_dq_hi", sram_dq_out, 16'hA5A5);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_addr_lo", sram_addr, 7);
    chk("mid_dq_lo", sram_dq_out, 16'h5A5A);
    wait_done(); idle_in();
    issue(1, 0, 32'd1036, 32'h0); idle_in();

    // async reset during the LO phase of a write (no expectation queued)
    mem_w_en = 1'b1; address = 32'd1424; data = 32'h11112222;
    repeat (3) @(posedge clk); #1;
    chk("abort_pre_we_n", sram_we_n, 0);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs("abort");
    @(posedge clk); #1;
    idle_in(); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_ready", ready, 1);

    // randomized traffic, some back-to-back
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = $urandom_range(0, 1023);
      else if (sel == 1) a = 32'(BASE) + (32'(IDX_LIM) << 2) + 4 * $urandom_range(0, 255);
      else               a = 32'(BASE) + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       issue(0, 1, a, $urandom);
        1:       issue(1, 0, a, 32'h0);
        default: issue(1, 1, a, $urandom);
      endcase
      if ($urandom_range(0, 3) != 0) idle_in();
    end
    idle_in();
    repeat (3) @(posedge clk); #1;
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences every MEM-stage data access onto an external 16-bit asynchronous SRAM.
- Splits each 32-bit word access into two halfword phases and inserts programmable wait states.
- Deasserts `ready` so the pipeline freezes until the access completes.
- Keeps the data-memory byte-address convention: base 1024, word-aligned, big-endian.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM halfword address width.
- WAIT_CYCLES, 1: wait cycles per halfword phase. Must be ≥ 1; the last cycle of each phase is the write-recovery/read-sample cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- mem_r_en  in  1  read request, held by the MEM stage until `ready`.
- mem_w_en  in  1  write request, held until `ready`.
- address  in  32  byte address (ALU result).
- data  in  32  write data (val_rm).
- data_memory_out  out  32  read data; holds its value until the next read completes.
- ready  out  1  access complete / no access pending; pipeline freezes while 0.
- sram_addr  out  SRAM_ADDR_W  halfword address.
- sram_dq_in  in  16  data from SRAM.
- sram_dq_out  out  16  data to SRAM.
- sram_dq_oe  out  1  tri-state enable for `sram_dq_out`.
- sram_ce_n  out  1  chip enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_oe_n  out  1  output enable, active low.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, wait counter 0, data_memory_out=0, sram_addr=0, sram_dq_out=0;
  - sram_dq_oe=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1.
  - `ready` is decoded from IDLE.
- Reset mid-access aborts the access immediately; no partial-write recovery. After reset deassertion, a pending request starts at the next edge.
- States: IDLE, HI, LO, DONE.
- Address map: word index = (address − BASE_ADDR) >> 2, truncated to SRAM_ADDR_W−1 bits.
  - HI phase: sram_addr = {index, 0}, carries data[31:16].
  - LO phase: sram_addr = {index, 1}, carries data[15:0].
  - address[1:0] is ignored.
- Out of range: address < BASE_ADDR or index ≥ 2^(SRAM_ADDR_W−1).
  - The full handshake still runs, but sram_ce_n stays 1 and no SRAM strobes toggle.
  - A read returns 0.
- Request priority: write wins if mem_w_en and mem_r_en are both 1.
- The operation type and address are latched on IDLE exit. Input changes mid-access are ignored.
- IDLE:
  - ready=1 when neither enable is set.
  - Any enable set gives ready=0 combinationally; the next edge moves to HI with counter=0.
- HI / LO:
  - The counter increments each cycle.
  - At counter==WAIT_CYCLES: HI→LO (counter cleared), or LO→DONE.
  - ce_n=0 throughout the phase.
  - Write: dq_oe=1; we_n=0 while counter<WAIT_CYCLES, we_n=1 on the last cycle.
  - Read: oe_n=0 throughout; sram_dq_in is captured on the last cycle (HI→rdata[31:16], LO→rdata[15:0]).
- DONE:
  - ready=1 for exactly one cycle; data_memory_out is updated for reads; all strobes are inactive.
  - Next edge → IDLE, unconditionally.
- Latency: ready is low for 2×(WAIT_CYCLES+1)+1 cycles and high in cycle 2×(WAIT_CYCLES+1)+2, counted from the cycle the request is first seen.
  - For WAIT_CYCLES=1: ready low for 5 cycles, high on the 6th.
- Back-to-back: a request still present in the IDLE cycle after DONE is treated as a new access.
- Writes do not modify data_memory_out.

Decomposition:
- Package arm_mem_pkg holds:
  - state encoding (IDLE=2'd0, HI=2'd1, LO=2'd2, DONE=2'd3);
  - the BASE_ADDR default;
  - the SRAM data width constant (16).
- No sub-module; the wait counter and address map stay inline.

Test Plan:
- Reset: hold rst=0 with mem_w_en=1 → all SRAM strobes 1, dq_oe=0, data_memory_out=0, ready=0 (request pending); first access starts one edge after release.
- Write then read (WAIT_CYCLES=1): write 0xDEADBEEF to 1028 → sram_addr 2 with dq_out 0xDEAD and we_n low 1 cycle, then addr 3 with 0xBEEF; ready low 5 cycles. Read 1028 → data_memory_out=0xDEADBEEF in the DONE cycle.
- Idle / concurrency:
  - Idle (both enables 0) → ready=1 continuously, ce_n=1.
  - Simultaneous r/w to 1032 with data 0x12345678 → write performed; a later read returns 0x12345678.
- Out of range: read of address 512 → no ce_n assertion, ready after the normal latency, data_memory_out=0.
- Mid-access: assert rst during the LO phase of a write → outputs reach reset values asynchronously, state IDLE. Changing address mid-access without reset leaves sram_addr unchanged.
